// File: rtl/t_up_arb.sv
// t_up_arb: arbiter and registered output stage for the up (u0) port of a
// BFT T-switch. The left and right children share the single parent link.
// Whole packets are granted by weighted round-robin. A starvation override
// acts only at packet boundaries.
`timescale 1ns/1ps
module t_up_arb #(
   parameter int A_W    = 3,
   parameter int D_W    = 32,
   parameter int W_L    = 2,
   parameter int W_R    = 1,
   parameter int STARVE = 12,
   parameter int CNT_W  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ce,
   input  logic [A_W+D_W:0] l_i,
   input  logic             l_i_v,
   output logic             l_i_bp,
   input  logic [A_W+D_W:0] r_i,
   input  logic             r_i_v,
   output logic             r_i_bp,
   output logic [A_W+D_W:0] u0_o,
   output logic             u0_o_v,
   input  logic             u0_o_bp,
   output logic [1:0]       gnt,
   output logic             busy,
   output logic             starve_evt
);
   localparam int LAST = A_W + D_W;
   localparam logic [CNT_W-1:0] WL_C     = CNT_W'(W_L);
   localparam logic [CNT_W-1:0] WR_C     = CNT_W'(W_R);
   localparam logic [CNT_W-1:0] STARVE_C = CNT_W'(STARVE);
   localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] WAIT_MAX = {CNT_W{1'b1}};
   localparam logic P_LEFT  = 1'b0;
   localparam logic P_RIGHT = 1'b1;

   typedef enum logic [1:0] {IDLE = 2'd0, LOCK_L = 2'd1, LOCK_R = 2'd2} state_t;

   state_t           state;
   logic             ptr;
   logic [CNT_W-1:0] cred_l, cred_r;
   logic [CNT_W-1:0] wait_l, wait_r;

   logic             can_load;
   logic             starve_l, starve_r, force_l, force_r, override;
   logic [1:0]       win;
   logic             l_fire, r_fire, l_done, r_done;
   logic             ptr_next;
   logic [CNT_W-1:0] cred_l_next, cred_r_next;
   logic [CNT_W-1:0] wait_l_next, wait_r_next;

   // The output register can take a flit when empty or draining this cycle.
   assign can_load = ce && (!u0_o_v || !u0_o_bp);

   // Starving requesters. When both starve, the longer wait wins and a tie goes left.
   assign starve_l = l_i_v && (wait_l >= STARVE_C);
   assign starve_r = r_i_v && (wait_r >= STARVE_C);
   assign force_l  = starve_l && (!starve_r || (wait_l >= wait_r));
   assign force_r  = starve_r && !force_l;
   assign override = ce && (state == IDLE) && (starve_l || starve_r);

   // Winner selection: a held lock, then the starvation override, then the pointer side, then the other side.
   always_comb begin
      win = 2'b00;
      case (state)
         LOCK_L: win = 2'b01;
         LOCK_R: win = 2'b10;
         default: begin
            if (force_l)
               win = 2'b01;
            else if (force_r)
               win = 2'b10;
            else if (ptr == P_LEFT)
               win = l_i_v ? 2'b01 : (r_i_v ? 2'b10 : 2'b00);
            else
               win = r_i_v ? 2'b10 : (l_i_v ? 2'b01 : 2'b00);
         end
      endcase
   end

   assign gnt    = rst_n ? win : 2'b00;
   assign busy   = (state != IDLE);
   assign l_i_bp = !(gnt[0] && can_load);
   assign r_i_bp = !(gnt[1] && can_load);
   assign l_fire = l_i_v && !l_i_bp;
   assign r_fire = r_i_v && !r_i_bp;
   assign l_done = l_fire && l_i[LAST];
   assign r_done = r_fire && r_i[LAST];

   // Pointer and credit update. An override beats the packet-completion accounting.
   always_comb begin
      ptr_next    = ptr;
      cred_l_next = cred_l;
      cred_r_next = cred_r;
      if (override) begin
         if (force_l) begin
            ptr_next    = P_LEFT;
            cred_l_next = WL_C;
         end else begin
            ptr_next    = P_RIGHT;
            cred_r_next = WR_C;
         end
      end else if (l_done) begin
         if (ptr == P_LEFT) begin
            cred_l_next = cred_l - C_ONE;
            if (cred_l == C_ONE) begin
               ptr_next    = P_RIGHT;
               cred_r_next = WR_C;
            end
         end else begin
            // The pointer side was idle: left takes the pointer and uses one credit.
            cred_l_next = WL_C - C_ONE;
            if (WL_C == C_ONE) begin
               ptr_next    = P_RIGHT;
               cred_r_next = WR_C;
            end else begin
               ptr_next = P_LEFT;
            end
         end
      end else if (r_done) begin
         if (ptr == P_RIGHT) begin
            cred_r_next = cred_r - C_ONE;
            if (cred_r == C_ONE) begin
               ptr_next    = P_LEFT;
               cred_l_next = WL_C;
            end
         end else begin
            cred_r_next = WR_C - C_ONE;
            if (WR_C == C_ONE) begin
               ptr_next    = P_LEFT;
               cred_l_next = WL_C;
            end else begin
               ptr_next = P_RIGHT;
            end
         end
      end
   end

   // Wait counters count denied cycles and saturate. They clear on service, on idle, or when their override fires.
   always_comb begin
      wait_l_next = '0;
      wait_r_next = '0;
      if (!(override && force_l) && l_i_v && !l_fire)
         wait_l_next = (wait_l == WAIT_MAX) ? wait_l : wait_l + C_ONE;
      if (!(override && force_r) && r_i_v && !r_fire)
         wait_r_next = (wait_r == WAIT_MAX) ? wait_r : wait_r + C_ONE;
   end

   // Packet-lock FSM together with the pointer, credit and override-pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         ptr        <= P_LEFT;
         cred_l     <= WL_C;
         cred_r     <= WR_C;
         starve_evt <= 1'b0;
      end else begin
         starve_evt <= override;
         if (ce) begin
            ptr    <= ptr_next;
            cred_l <= cred_l_next;
            cred_r <= cred_r_next;
            case (state)
               IDLE: begin
                  if (l_fire && !l_i[LAST])
                     state <= LOCK_L;
                  else if (r_fire && !r_i[LAST])
                     state <= LOCK_R;
               end
               LOCK_L: if (l_done) state <= IDLE;
               LOCK_R: if (r_done) state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

   // Starvation wait counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_l <= '0;
         wait_r <= '0;
      end else if (ce) begin
         wait_l <= wait_l_next;
         wait_r <= wait_r_next;
      end
   end

   // Output register. A new flit loads in the same cycle the old one drains.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         u0_o   <= '0;
         u0_o_v <= 1'b0;
      end else if (ce) begin
         if (l_fire) begin
            u0_o   <= l_i;
            u0_o_v <= 1'b1;
         end else if (r_fire) begin
            u0_o   <= r_i;
            u0_o_v <= 1'b1;
         end else if (u0_o_v && !u0_o_bp) begin
            u0_o_v <= 1'b0;
         end
      end
   end
endmodule
